i2c_bias_updater: RTL and testbench

I2C_BIAS_UPDATER -- requirements
Module: i2c_bias_updater

---
 rtl/i2c_bias_updater.sv | 185 ++++++++++++++++++
 tb/tb_i2c_bias_updater.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bias_updater.sv
// Keeps two digipot wipers in step with the bias0/bias1 requests: waits for the
// inputs to settle, then issues one I2C write (command byte + value) per changed wiper.
module i2c_bias_updater #(
  parameter logic [6:0]  DEV_ADDR      = 7'h2C,
  parameter logic [7:0]  WIPER0_CMD    = 8'h00,
  parameter logic [7:0]  WIPER1_CMD    = 8'h10,
  parameter logic [15:0] SETTLE_CYCLES = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bias0,
  input  logic [7:0] bias1,
  output logic [6:0] cmd_address,
  output logic       cmd_start,
  output logic       cmd_read,
  output logic       cmd_write,
  output logic       cmd_write_multiple,
  output logic       cmd_stop,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       data_out_last,
  output logic       busy
);

  localparam logic [15:0] SETTLE_EFF = (SETTLE_CYCLES == 16'd0) ? 16'd1 : SETTLE_CYCLES;

  typedef enum logic [2:0] {IDLE, SETTLE, CMD, DATA_REG, DATA_VAL} state_t;

  state_t      state_reg;
  logic [7:0]  bias0_q;
  logic [7:0]  bias1_q;
  logic [15:0] settle_cnt_reg;
  logic [7:0]  val_reg;
  logic        sel_reg;
  logic [1:0]  pending;
  logic        input_change;
  logic        settled;
  logic        last_accept;
  logic [7:0]  bias_in [2];

  assign bias_in[0] = bias0;
  assign bias_in[1] = bias1;

  assign cmd_read  = 1'b0;
  assign cmd_write = 1'b0;

  assign input_change = (bias0 != bias0_q) || (bias1 != bias1_q);
  assign settled      = !input_change && (settle_cnt_reg >= SETTLE_EFF);
  assign last_accept  = (state_reg == DATA_VAL) && data_out_ready;

  // The counter runs in every state so a change made during a transaction
  // still has its settle time measured from the moment it happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bias0_q        <= 8'h00;
      bias1_q        <= 8'h00;
      settle_cnt_reg <= 16'd0;
    end else begin
      bias0_q <= bias0;
      bias1_q <= bias1;
      if (input_change)
        settle_cnt_reg <= 16'd0;
      else if (settle_cnt_reg != 16'hFFFF)
        settle_cnt_reg <= settle_cnt_reg + 16'd1;
    end
  end

  // Per-wiper shadow and pending flag. force_reg keeps a wiper pending after
  // reset even when the request happens to equal the reset shadow value.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
      logic [7:0] sh_reg;
      logic       p_reg;
      logic       force_reg;
      logic       my_accept;

      assign my_accept   = last_accept && (sel_reg == gi[0]);
      assign pending[gi] = p_reg;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sh_reg    <= 8'h00;
          p_reg     <= 1'b1;
          force_reg <= 1'b1;
        end else if (my_accept) begin
          sh_reg    <= val_reg;
          force_reg <= 1'b0;
          p_reg     <= (bias_in[gi] != val_reg);
        end else if (bias_in[gi] != sh_reg) begin
          p_reg <= 1'b1;
        end else if (!force_reg) begin
          p_reg <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      cmd_address        <= 7'd0;
      cmd_start          <= 1'b0;
      cmd_write_multiple <= 1'b0;
      cmd_stop           <= 1'b0;
      cmd_valid          <= 1'b0;
      data_out           <= 8'h00;
      data_out_valid     <= 1'b0;
      data_out_last      <= 1'b0;
      busy               <= 1'b0;
      val_reg            <= 8'h00;
      sel_reg            <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (|pending) begin
            state_reg <= SETTLE;
            busy      <= 1'b1;
          end
        end
        SETTLE: begin
          if (!(|pending)) begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end else if (settled) begin
            sel_reg            <= !pending[0];
            val_reg            <= pending[0] ? bias0 : bias1;
            cmd_address        <= DEV_ADDR;
            cmd_start          <= 1'b1;
            cmd_write_multiple <= 1'b1;
            cmd_stop           <= 1'b1;
            cmd_valid          <= 1'b1;
            state_reg          <= CMD;
          end
        end
        CMD: begin
          if (cmd_ready) begin
            cmd_start          <= 1'b0;
            cmd_write_multiple <= 1'b0;
            cmd_stop           <= 1'b0;
            cmd_valid          <= 1'b0;
            data_out           <= sel_reg ? WIPER1_CMD : WIPER0_CMD;
            data_out_valid     <= 1'b1;
            data_out_last      <= 1'b0;
            state_reg          <= DATA_REG;
          end
        end
        DATA_REG: begin
          if (data_out_ready) begin
            data_out      <= val_reg;
            data_out_last <= 1'b1;
            state_reg     <= DATA_VAL;
          end
        end
        DATA_VAL: begin
          if (data_out_ready) begin
            data_out_valid <= 1'b0;
            data_out_last  <= 1'b0;
            // The other wiper goes straight out without a fresh settle.
            if (pending[!sel_reg]) begin
              sel_reg            <= !sel_reg;
              val_reg            <= sel_reg ? bias0 : bias1;
              cmd_address        <= DEV_ADDR;
              cmd_start          <= 1'b1;
              cmd_write_multiple <= 1'b1;
              cmd_stop           <= 1'b1;
              cmd_valid          <= 1'b1;
              state_reg          <= CMD;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bias_updater.sv
// Directed bench for i2c_bias_updater with SETTLE_CYCLES=100: logs handshaken
// beats at the falling edge and compares them against hand-computed writes.
module tb_i2c_bias_updater;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] bias0, bias1;
  logic [6:0] cmd_address;
  logic       cmd_start, cmd_read, cmd_write, cmd_write_multiple, cmd_stop;
  logic       cmd_valid, cmd_ready;
  logic [7:0] data_out;
  logic       data_out_valid, data_out_ready, data_out_last;
  logic       busy;

  i2c_bias_updater #(
    .DEV_ADDR(7'h2C), .WIPER0_CMD(8'h00), .WIPER1_CMD(8'h10), .SETTLE_CYCLES(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .bias0(bias0), .bias1(bias1),
    .cmd_address(cmd_address), .cmd_start(cmd_start), .cmd_read(cmd_read),
    .cmd_write(cmd_write), .cmd_write_multiple(cmd_write_multiple), .cmd_stop(cmd_stop),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready), .data_out_last(data_out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cmd_cnt = 0;
  int         bad_fields = 0;
  int         first_rise = -1;
  logic       cv_prev = 1'b0;
  logic [7:0] reg_byte = 8'h00;
  logic [8:0] beat_q [$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && !cv_prev && first_rise < 0) first_rise = cyc;
      if (cmd_valid && cmd_ready) begin
        cmd_cnt++;
        if (cmd_address !== 7'h2C || cmd_start !== 1'b1 || cmd_write_multiple !== 1'b1 ||
            cmd_stop !== 1'b1 || cmd_read !== 1'b0 || cmd_write !== 1'b0)
          bad_fields++;
      end
      if (data_out_valid && data_out_ready) begin
        beat_q.push_back({data_out_last, data_out});
        if (!data_out_last) reg_byte = data_out;
        else $display("txn @%0d: reg %h val %h", cyc, reg_byte, data_out);
      end
    end
    cv_prev = cmd_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    beat_q.delete();
    cmd_cnt    = 0;
    first_rise = -1;
  endtask

  task automatic wait_done(input string tag, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk); #1;
      if (cmd_cnt >= n && !busy) ok = 1'b1;
    end
    check({tag, "_done"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_sig(input string tag, input bit use_data);
    bit ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk); #1;
      if (use_data ? data_out_valid : cmd_valid) ok = 1'b1;
    end
    check({tag, "_seen"}, {31'd0, ok}, 32'd1);
  endtask

  task automatic expect_txn(input string tag, input int idx, input logic [7:0] rb, input logic [7:0] vb);
    logic [8:0] a, b;
    a = (beat_q.size() > 2 * idx)     ? beat_q[2 * idx]     : 9'h1FF;
    b = (beat_q.size() > 2 * idx + 1) ? beat_q[2 * idx + 1] : 9'h1FF;
    check({tag, "_reg"}, {23'd0, a}, {23'd0, 1'b0, rb});
    check({tag, "_val"}, {23'd0, b}, {23'd0, 1'b1, vb});
  endtask

  initial begin
    int t_ref;
    int unstable;
    rst = 1'b1; bias0 = 8'h40; bias1 = 8'h80; cmd_ready = 1'b1; data_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_dvalid", {31'd0, data_out_valid}, 32'd0);
    check("rst_dlast", {31'd0, data_out_last}, 32'd0);

    // Both wipers rewritten after reset release.
    clear_log();
    t_ref = cyc;
    rst = 1'b0;
    wait_done("boot", 2);
    check("boot_cmds", cmd_cnt, 2);
    check("boot_beats", beat_q.size(), 4);
    expect_txn("boot_w0", 0, 8'h00, 8'h40);
    expect_txn("boot_w1", 1, 8'h10, 8'h80);
    check("boot_latency", first_rise - t_ref, 102);

    // Three changes 10 cycles apart collapse into one write of the last value.
    clear_log();
    @(posedge clk); #1; bias0 = 8'h11;
    repeat (10) @(posedge clk);
    #1; bias0 = 8'h22;
    repeat (10) @(posedge clk);
    #1; bias0 = 8'h33; t_ref = cyc;
    wait_done("settle", 1);
    check("settle_cmds", cmd_cnt, 1);
    check("settle_beats", beat_q.size(), 2);
    expect_txn("settle_w0", 0, 8'h00, 8'h33);
    check("settle_latency", first_rise - t_ref, 102);

    // Command stalled on cmd_ready: fields held, no data beat yet.
    clear_log();
    cmd_ready = 1'b0;
    @(posedge clk); #1; bias1 = 8'h55;
    wait_sig("stall_cmd", 1'b0);
    unstable = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (!cmd_valid || cmd_address !== 7'h2C || !cmd_start || !cmd_write_multiple ||
          !cmd_stop || cmd_read || cmd_write || data_out_valid)
        unstable++;
    end
    check("stall_hold", unstable, 0);
    cmd_ready = 1'b1;
    wait_done("stall", 1);
    check("stall_beats", beat_q.size(), 2);
    expect_txn("stall_w1", 0, 8'h10, 8'h55);

    // Change bias1 while the value beat is stalled; the new value follows later.
    clear_log();
    data_out_ready = 1'b0;
    @(posedge clk); #1; bias1 = 8'h66;
    wait_sig("dstall", 1'b1);
    check("dstall_regbyte", {24'd0, data_out}, 32'h10);
    data_out_ready = 1'b1;
    @(posedge clk); #1;
    data_out_ready = 1'b0;
    check("dstall_last", {31'd0, data_out_last}, 32'd1);
    bias1 = 8'h77;
    repeat (20) @(posedge clk);
    #1;
    check("dstall_hold_data", {24'd0, data_out}, 32'h66);
    check("dstall_hold_valid", {31'd0, data_out_valid}, 32'd1);
    data_out_ready = 1'b1;
    wait_done("dstall", 2);
    check("dstall_beats", beat_q.size(), 4);
    expect_txn("dstall_old", 0, 8'h10, 8'h66);
    expect_txn("dstall_new", 1, 8'h10, 8'h77);

    // Reset while sitting in the command-byte beat.
    data_out_ready = 1'b0;
    @(posedge clk); #1; bias0 = 8'h44;
    wait_sig("midrst", 1'b1);
    check("midrst_regbyte", {24'd0, data_out}, 32'h00);
    rst = 1'b1;
    #1;
    check("midrst_dvalid", {31'd0, data_out_valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    clear_log();
    rst = 1'b0;
    data_out_ready = 1'b1;
    wait_done("midrst", 2);
    check("midrst_beats", beat_q.size(), 4);
    expect_txn("midrst_w0", 0, 8'h00, 8'h44);
    expect_txn("midrst_w1", 1, 8'h10, 8'h77);

    // Request reverted to the shadow value before settle expires.
    clear_log();
    @(posedge clk); #1; bias0 = 8'h99;
    repeat (20) @(posedge clk);
    #1;
    check("revert_busy_hi", {31'd0, busy}, 32'd1);
    bias0 = 8'h44;
    repeat (5) @(posedge clk);
    #1;
    check("revert_busy_lo", {31'd0, busy}, 32'd0);
    repeat (150) @(posedge clk);
    #1;
    check("revert_cmds", cmd_cnt, 0);
    check("revert_busy_end", {31'd0, busy}, 32'd0);

    check("cmd_fields", bad_fields, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
